i2c_bit_sequencer: RTL and testbench

//  Bit-level timing controller for the I2C master: consumes START/STOP/WRITE/READ

---
 rtl/i2c_bit_sequencer.sv | 173 +++++++++++++++++
 tb/tb_i2c_bit_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_sequencer.sv
// i2c_bit_sequencer: command-driven I2C bit timing. Each START/STOP/WRITE/READ
// runs four quarter-bit phases of (clk_div+1) cycles, driving open-drain SCL/SDA
// release enables and honouring slave clock stretching on SCL-high phases.
module i2c_bit_sequencer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic             cmd_bit,
  output logic             rsp_valid,
  output logic             rsp_bit,
  output logic             busy,
  output logic             scl_o,
  output logic             sda_o,
  input  logic             scl_i,
  input  logic             sda_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_Q0   = 3'd1;
  localparam logic [2:0] S_Q1   = 3'd2;
  localparam logic [2:0] S_Q2   = 3'd3;
  localparam logic [2:0] S_Q3   = 3'd4;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             bit_q, bit_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_bit_q, rsp_bit_d;

  logic             accept;
  logic             stretch;
  logic             phase_done;
  logic [1:0]       lines;

  // {scl, sda} release pattern for a given command and phase
  function automatic logic [1:0] phase_lines(input logic [1:0] c, input logic b,
                                             input logic [2:0] ph);
    logic       d;
    logic [1:0] r;
    d = c[0] ? 1'b1 : b;
    r = 2'b11;
    case (c)
      CMD_START: begin
        case (ph)
          S_Q2:    r = 2'b10;
          S_Q3:    r = 2'b00;
          default: r = 2'b11;
        endcase
      end
      CMD_STOP: begin
        case (ph)
          S_Q0:    r = 2'b00;
          S_Q3:    r = 2'b11;
          default: r = 2'b10;
        endcase
      end
      default: begin
        case (ph)
          S_Q1, S_Q2: r = {1'b1, d};
          default:    r = {1'b0, d};
        endcase
      end
    endcase
    return r;
  endfunction

  assign accept     = cmd_valid & ready_q;
  assign stretch    = scl_q & ~scl_i;
  assign phase_done = (cnt_q == div_q) & ~stretch;

  // next-state, phase counter and line pattern selection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    cmd_d       = cmd_q;
    bit_d       = bit_q;
    scl_d       = scl_q;
    sda_d       = sda_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit_q;
    lines       = 2'b11;

    if (state_q == S_IDLE) begin
      if (accept) begin
        state_d = S_Q0;
        cnt_d   = '0;
        div_d   = clk_div;
        cmd_d   = cmd;
        bit_d   = cmd_bit;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        lines   = phase_lines(cmd, cmd_bit, S_Q0);
        scl_d   = lines[1];
        sda_d   = lines[0];
      end
    end else if (stretch) begin
      // slave holds SCL low: phase time restarts once SCL is seen high
      cnt_d = '0;
    end else if (phase_done) begin
      cnt_d = '0;
      if (state_q == S_Q1) begin
        rsp_bit_d = cmd_q[1] ? sda_i : 1'b1;
      end
      if (state_q == S_Q3) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        ready_d     = 1'b1;
        busy_d      = 1'b0;
      end else begin
        state_d = 3'(state_q + 3'd1);
        lines   = phase_lines(cmd_q, bit_q, 3'(state_q + 3'd1));
        scl_d   = lines[1];
        sda_d   = lines[0];
      end
    end else begin
      cnt_d = DIV_W'(cnt_q + 1'b1);
    end
  end

  // state and registered outputs; reset releases both lines
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      cmd_q       <= '0;
      bit_q       <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      cmd_q       <= cmd_d;
      bit_q       <= bit_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bit   = rsp_bit_q;
  assign scl_o     = scl_q;
  assign sda_o     = sda_q;

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// tb_i2c_bit_sequencer: scenario tasks plus a response scoreboard keyed on
// expected completion cycle and expected rsp_bit.
module tb_i2c_bit_sequencer;

  localparam logic [1:0] START = 2'b00;
  localparam logic [1:0] STOP  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] READ  = 2'b11;

  logic        clk;
  logic        rst;
  logic [15:0] clk_div;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic        cmd_bit;
  logic        rsp_valid;
  logic        rsp_bit;
  logic        busy;
  logic        scl_o;
  logic        sda_o;
  logic        scl_i;
  logic        sda_i;
  logic        hold_scl;
  logic        slave_sda;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  int   exp_cyc_q[$];
  logic exp_bit_q[$];

  // open-drain bus: slave may stretch SCL or pull SDA low
  assign scl_i = scl_o & ~hold_scl;
  assign sda_i = sda_o & slave_sda;

  i2c_bit_sequencer #(.DIV_W(16)) dut (
    .clk_i     (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .cmd_bit   (cmd_bit),
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .busy      (busy),
    .scl_o     (scl_o),
    .sda_o     (sda_o),
    .scl_i     (scl_i),
    .sda_i     (sda_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every rsp_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    int   ec;
    logic eb;
    if (rsp_valid === 1'b1) begin
      ntests++;
      if (exp_cyc_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        ec = exp_cyc_q.pop_front();
        eb = exp_bit_q.pop_front();
        if (cyc !== ec) begin
          nfail++;
          $display("FAIL rsp_cycle: got cycle %0d, required %0d", cyc, ec);
        end
        ntests++;
        if (rsp_bit !== eb) begin
          nfail++;
          $display("FAIL rsp_bit: got %b, required %b (cycle %0d)", rsp_bit, eb, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic exp_bit(input logic [1:0] c, input logic b);
    if (!c[1]) return 1'b1;
    return (c[0] ? 1'b1 : b) & slave_sda;
  endfunction

  // waits (at negedges) for cmd_ready, then presents a command for one accept
  task automatic send(input logic [1:0] c, input logic b, input logic [15:0] div,
                      input int lat, input bit push, output int acc);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      ntests++;
      nfail++;
      $display("FAIL send_timeout: cmd_ready=%b, required 1", cmd_ready);
    end
    cmd       = c;
    cmd_bit   = b;
    clk_div   = div;
    cmd_valid = 1'b1;
    acc       = cyc;
    if (push) begin
      exp_cyc_q.push_back(cyc + lat);
      exp_bit_q.push_back(exp_bit(c, b));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ntests++; if (scl_o !== 1'b1)     begin nfail++; $display("FAIL reset_scl: got %b, required 1", scl_o); end
    ntests++; if (sda_o !== 1'b1)     begin nfail++; $display("FAIL reset_sda: got %b, required 1", sda_o); end
    ntests++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
    ntests++; if (busy !== 1'b0)      begin nfail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    ntests++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    ntests++; if (rsp_bit !== 1'b0)   begin nfail++; $display("FAIL reset_rsp_bit: got %b, required 0", rsp_bit); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    int acc;
    int sda_f = -1;
    int scl_f = -1;
    send(START, 1'b0, 16'd4, 21, 1'b1, acc);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      clk_div   = 16'd0;
      if (i == 1) begin
        ntests++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
          nfail++;
          $display("FAIL start_busy: busy=%b ready=%b, required 1/0", busy, cmd_ready);
        end
      end
      if (sda_o === 1'b0 && sda_f < 0) sda_f = cyc - acc;
      if (scl_o === 1'b0 && scl_f < 0) scl_f = cyc - acc;
      if (cyc - acc == 21) begin
        ntests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
          nfail++;
          $display("FAIL start_done_ready: ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end
      end
    end
    ntests++; if (sda_f != 11) begin nfail++; $display("FAIL start_sda_fall: got +%0d, required +11", sda_f); end
    ntests++; if (scl_f != 16) begin nfail++; $display("FAIL start_scl_fall: got +%0d, required +16", scl_f); end
  endtask

  task automatic test_write_read();
    logic [1:0] cs[4] = '{WRITE, READ, READ, WRITE};
    logic       bs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       ss[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int acc;
    int hi;
    int bad;
    logic exp_sda;
    for (int k = 0; k < 4; k++) begin
      slave_sda = ss[k];
      exp_sda   = cs[k][0] ? 1'b1 : bs[k];
      hi  = 0;
      bad = 0;
      send(cs[k], bs[k], 16'd4, 21, 1'b1, acc);
      for (int i = 1; i <= 21; i++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (i <= 20) begin
          if (scl_o === 1'b1) hi++;
          if (sda_o !== exp_sda) bad++;
        end
      end
      ntests++; if (hi != 10) begin nfail++; $display("FAIL wr_scl_high[%0d]: got %0d cycles, required 10", k, hi); end
      ntests++; if (bad != 0) begin nfail++; $display("FAIL wr_sda_level[%0d]: %0d cycles differ from %b", k, bad, exp_sda); end
    end
    slave_sda = 1'b1;
  endtask

  task automatic test_stretch();
    int acc;
    slave_sda = 1'b1;
    send(WRITE, 1'b1, 16'd2, 33, 1'b1, acc);
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (cyc - acc == 3)  hold_scl = 1'b1;
      if (cyc - acc == 24) hold_scl = 1'b0;
      if (cyc - acc == 32) begin
        ntests++;
        if (busy !== 1'b1 || scl_o !== 1'b0) begin
          nfail++;
          $display("FAIL stretch_q3: busy=%b scl=%b, required 1/0", busy, scl_o);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq_c[10];
    logic       seq_b[10];
    int acc;
    int prev;
    int n;
    slave_sda = 1'b1;
    seq_c[0] = START; seq_b[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      seq_c[i] = WRITE;
      seq_b[i] = 1'($urandom_range(1, 0));
    end
    seq_c[9] = STOP; seq_b[9] = 1'b0;
    send(seq_c[0], seq_b[0], 16'd0, 5, 1'b1, acc);
    prev = acc;
    for (int j = 1; j < 10; j++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (cmd_ready !== 1'b1 && n < 20);
      ntests++;
      if (cyc - prev != 5 || rsp_valid !== 1'b1) begin
        nfail++;
        $display("FAIL b2b_accept[%0d]: gap %0d rsp_valid=%b, required gap 5 rsp_valid=1", j, cyc - prev, rsp_valid);
      end
      cmd     = seq_c[j];
      cmd_bit = seq_b[j];
      exp_cyc_q.push_back(cyc + 5);
      exp_bit_q.push_back(exp_bit(seq_c[j], seq_b[j]));
      prev = cyc;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (scl_o !== 1'b1 || sda_o !== 1'b1) begin
      nfail++;
      $display("FAIL b2b_final_lines: scl=%b sda=%b, required 1/1", scl_o, sda_o);
    end
  endtask

  task automatic test_reset_abort();
    logic [1:0] cs[2]  = '{READ, WRITE};
    logic       bs[2]  = '{1'b0, 1'b0};
    int         off[2] = '{10, 14};
    int acc;
    for (int k = 0; k < 2; k++) begin
      send(cs[k], bs[k], 16'd3, 17, 1'b0, acc);
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (cyc - acc == off[k]) break;
      end
      rst = 1'b1;
      @(negedge clk);
      ntests++;
      if (scl_o !== 1'b1 || sda_o !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
        nfail++;
        $display("FAIL abort[%0d]: scl=%b sda=%b ready=%b busy=%b rsp=%b, required 1 1 1 0 0",
                 k, scl_o, sda_o, cmd_ready, busy, rsp_valid);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = START;
    cmd_bit   = 1'b0;
    clk_div   = 16'd0;
    hold_scl  = 1'b0;
    slave_sda = 1'b1;
    test_reset();
    test_start();
    test_write_read();
    test_stretch();
    test_back_to_back();
    test_reset_abort();
    ntests++;
    if (exp_cyc_q.size() != 0) begin
      nfail++;
      $display("FAIL missing_rsp: %0d responses outstanding, required 0", exp_cyc_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
